alu: RTL and testbench

Registered 32-bit integer ALU for the RISC-V datapath execute stage. It applies one of eight operations, selected by a 3-bit code, to two register operands and presents the result on a clocked output one cycle later. It sits between the register-file read ports and the writeback mux.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_shifter.sv | 28 ++
 rtl/alu.sv | 76 +++++++
 tb/tb_alu.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encoding for the execute-stage ALU.
//   alu_op_e      - 3-bit operation select (ADD..SRA), shared with decode/control
//   ALU_SEL_W     - width of the operation select
//   alu_shift_e   - shift kind fed to alu_shifter
//   op_to_shift() - maps a shift operation to its shifter kind
package alu_pkg;

  localparam int ALU_SEL_W = 3;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } alu_shift_e;

  // Any non-shift op maps to SLL; its shifter output is simply not selected.
  function automatic alu_shift_e op_to_shift(input alu_op_e op);
    case (op)
      ALU_SRL: return SH_SRL;
      ALU_SRA: return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter for SLL/SRL/SRA.
// Ports:
//   data_i  [WIDTH-1:0]          value to shift
//   shamt_i [$clog2(WIDTH)-1:0]  shift amount
//   kind_i  [1:0]                SH_SLL / SH_SRL / SH_SRA
//   res_o   [WIDTH-1:0]          shifted result
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  input  logic [1:0]               kind_i,
  output logic [WIDTH-1:0]         res_o
);

  always_comb begin
    res_o = '0;
    case (kind_i)
      SH_SLL:  res_o = data_i << shamt_i;
      SH_SRL:  res_o = data_i >> shamt_i;
      // Unused encoding 3 behaves as SRA so the output is always defined.
      default: res_o = WIDTH'($signed(data_i) >>> shamt_i);
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: registered integer ALU for the execute stage, one-cycle latency.
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset (sal=0, zero=1)
//   rs1, rs2       operands; shifts use rs2[$clog2(WIDTH)-1:0] only
//   sel            operation select, alu_pkg::alu_op_e encoding
//   sal            registered result
//   zero           registered "result == 0" flag, present only when
//                  ALU_ZERO_FLAG_EN is defined
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     rs1,
  input  logic [WIDTH-1:0]     rs2,
  input  logic [ALU_SEL_W-1:0] sel,
  output logic [WIDTH-1:0]     sal
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic                 zero
`endif
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_e          op;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] sal_d;
  logic [WIDTH-1:0] sal_q;

  assign op = alu_op_e'(sel);

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .data_i  (rs1),
    .shamt_i (rs2[SHW-1:0]),
    .kind_i  (op_to_shift(op)),
    .res_o   (shift_res)
  );

  always_comb begin
    sal_d = '0;
    case (op)
      ALU_ADD: sal_d = rs1 + rs2;
      ALU_SUB: sal_d = rs1 - rs2;
      ALU_AND: sal_d = rs1 & rs2;
      ALU_OR:  sal_d = rs1 | rs2;
      ALU_XOR: sal_d = rs1 ^ rs2;
      default: sal_d = shift_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sal_q <= '0;
    else        sal_q <= sal_d;
  end

  assign sal = sal_q;

`ifdef ALU_ZERO_FLAG_EN
  logic zero_d;
  logic zero_q;

  assign zero_d = (sal_d == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) zero_q <= 1'b1;
    else        zero_q <= zero_d;
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu. The driver pushes the expected
// registered response for every cycle it drives; the monitor pops one
// entry after each rising edge and compares.
module tb_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] rs1, rs2;
  logic [2:0]   sel;
  logic [W-1:0] sal;
  logic         zero_w;

  always #5 clk = ~clk;

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs1   (rs1),
    .rs2   (rs2),
    .sel   (sel),
    .sal   (sal)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .zero  (zero_w)
`endif
  );

`ifndef ALU_ZERO_FLAG_EN
  assign zero_w = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    string        tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: plain integer arithmetic on 64-bit values, truncated to W.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] s);
    logic [63:0] ua, ub, pw, tmp;
    int unsigned sh;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sh = b % W;
    pw = 64'd1 << sh;
    case (s)
      3'd0: tmp = ua + ub;
      3'd1: tmp = ua + (64'h1_0000_0000 - ub);
      3'd2: tmp = ua & ub;
      3'd3: tmp = ua | ub;
      3'd4: tmp = ua ^ ub;
      3'd5: tmp = ua * pw;
      3'd6: tmp = ua / pw;
      default: begin
        // floor division of a negative number: -(((-a-1)/2^k)+1)
        if (a[W-1]) tmp = {32'b0, ~(32'((~ua[31:0]) / pw[31:0]))};
        else        tmp = ua / pw;
      end
    endcase
    return tmp[W-1:0];
  endfunction

  task automatic drive(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] s, input string tag);
    exp_t e;
    rst_n = r;
    rs1   = a;
    rs2   = b;
    sel   = s;
    if (!r) begin
      e.res = '0;
      e.z   = 1'b1;
    end else begin
      e.res = model(a, b, s);
      e.z   = (e.res == '0);
    end
    e.tag = tag;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: DUT updates every edge, so one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (sal !== e.res) begin
          bad++;
          $display("FAIL %s sal: got %h expected %h", e.tag, sal, e.res);
        end
`ifdef ALU_ZERO_FLAG_EN
        total++;
        if (zero_w !== e.z) begin
          bad++;
          $display("FAIL %s zero: got %b expected %b", e.tag, zero_w, e.z);
        end
`endif
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    logic [2:0]   s;
    logic         r;

    drive(1'b0, 32'd226, 32'd7, 3'd0, "reset0");
    drive(1'b0, 32'd226, 32'd7, 3'd0, "reset1");

    for (int i = 0; i < 8; i++)
      drive(1'b1, 32'd226, 32'd7, 3'(i), $sformatf("sweep_sel%0d", i));

    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0, "add_wrap");
    drive(1'b1, 32'd0, 32'd1, 3'd1, "sub_wrap");
    drive(1'b1, 32'h8000_0000, 32'd4, 3'd7, "sra_neg");
    drive(1'b1, 32'h8000_0000, 32'd4, 3'd6, "srl_neg");
    drive(1'b1, 32'd1, 32'h21, 3'd5, "sll_trunc");
    drive(1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'd7, "sra_max");
    drive(1'b1, 32'h1234_5678, 32'd0, 3'd6, "srl_zero");

    // Mid-stream reset: the op sampled with rst_n low is discarded.
    drive(1'b1, 32'd10, 32'd3, 3'd0, "mid_op0");
    drive(1'b1, 32'd10, 32'd3, 3'd1, "mid_op1");
    drive(1'b0, 32'd10, 32'd3, 3'd3, "mid_rst");
    drive(1'b1, 32'd10, 32'd3, 3'd4, "mid_after");

    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = $urandom;
      s = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: b = a;                  // forces zero for SUB/XOR
        1: a = 32'h8000_0000 | a;
        2: b = 32'($urandom_range(0, 40));
        default: ;
      endcase
      r = ($urandom_range(0, 29) != 0);
      drive(r, a, b, s, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
